// File: rtl/com_seq_pipe_if.sv
// Operand/result bundle for com_seq_pipe: master drives operands and controls, slave returns results.
// in_valid qualifies A/B/C/mode for one edge; there is no back-pressure, hold freezes the pipe and drops offered items.
interface com_seq_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [1:0]       mode;
  logic             in_valid;
  logic             hold;
  logic             clr;
  logic [WIDTH-1:0] D;
  logic             F;
  logic             out_valid;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output A, B, C, mode, in_valid, hold, clr,
    input  D, F, out_valid, match_cnt
  );

  modport slave (
    input  A, B, C, mode, in_valid, hold, clr,
    output D, F, out_valid, match_cnt
  );
endinterface

// File: rtl/com_seq_pipe.sv
// Mode-selected 3-operand bitwise function with odd-parity flag, carried through a
// valid-tagged pipeline with global hold, plus a saturating count of delivered flagged items.
module com_seq_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  com_seq_pipe_if.slave    bus
);

  logic [WIDTH-1:0] r;
  logic             f;

  logic             v_q    [STAGES];
  logic [WIDTH-1:0] data_q [STAGES];
  logic             flag_q [STAGES];
  logic [CNT_W-1:0] cnt_q;

  logic             last_v;
  logic             last_f;

  always_comb begin
    r = '0;
    case (bus.mode)
      2'b00:   r = (bus.A & bus.B) | bus.C;
      2'b01:   r = bus.A ^ bus.B ^ bus.C;
      2'b10:   r = (bus.A & bus.B) | (bus.B & bus.C) | (bus.A & bus.C);
      default: r = ~(bus.A | bus.B) & bus.C;
    endcase
    f = ^r;
  end

  // The item about to enter the last stage decides whether the counter steps.
  generate
    if (STAGES == 1) begin : g_single
      assign last_v = bus.in_valid;
      assign last_f = f;
    end else begin : g_multi
      assign last_v = v_q[STAGES-2];
      assign last_f = flag_q[STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= 1'b0;
        data_q[k] <= '0;
        flag_q[k] <= 1'b0;
      end
    end else if (!bus.hold) begin
      v_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        data_q[0] <= r;
        flag_q[0] <= f;
      end
      // Bubbles advance only the valid bit so the last delivered item stays visible.
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          data_q[k] <= data_q[k-1];
          flag_q[k] <= flag_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr) begin
      cnt_q <= '0;
    end else if (!bus.hold && last_v && last_f && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.D         = data_q[STAGES-1];
  assign bus.F         = flag_q[STAGES-1];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_com_seq_pipe.sv
// Directed bench for com_seq_pipe: three instances (STAGES=1,2,4) share one stimulus stream.
module tb_com_seq_pipe;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b, c;
  logic [1:0] mode;
  logic       in_valid, hold, clr;

  int checks   = 0;
  int failures = 0;

  com_seq_pipe_if #(.WIDTH(4), .CNT_W(8)) if1 ();
  com_seq_pipe_if #(.WIDTH(4), .CNT_W(8)) if2 ();
  com_seq_pipe_if #(.WIDTH(4), .CNT_W(8)) if4 ();

  assign if1.A = a;  assign if1.B = b;  assign if1.C = c;  assign if1.mode = mode;
  assign if1.in_valid = in_valid;  assign if1.hold = hold;  assign if1.clr = clr;
  assign if2.A = a;  assign if2.B = b;  assign if2.C = c;  assign if2.mode = mode;
  assign if2.in_valid = in_valid;  assign if2.hold = hold;  assign if2.clr = clr;
  assign if4.A = a;  assign if4.B = b;  assign if4.C = c;  assign if4.mode = mode;
  assign if4.in_valid = in_valid;  assign if4.hold = hold;  assign if4.clr = clr;

  com_seq_pipe #(.WIDTH(4), .STAGES(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  com_seq_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  com_seq_pipe #(.WIDTH(4), .STAGES(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  // Index 0/1/2 -> STAGES 1/2/4
  logic [3:0] d_o  [3];
  logic       f_o  [3];
  logic       ov_o [3];
  logic [7:0] cnt_o[3];
  int         lat  [3] = '{1, 2, 4};

  assign d_o[0] = if1.D;  assign f_o[0] = if1.F;  assign ov_o[0] = if1.out_valid;  assign cnt_o[0] = if1.match_cnt;
  assign d_o[1] = if2.D;  assign f_o[1] = if2.F;  assign ov_o[1] = if2.out_valid;  assign cnt_o[1] = if2.match_cnt;
  assign d_o[2] = if4.D;  assign f_o[2] = if4.F;  assign ov_o[2] = if4.out_valid;  assign cnt_o[2] = if4.match_cnt;

  logic [3:0] sweep_d[4] = '{4'b1001, 4'b1110, 4'b0001, 4'b1000};
  logic       sweep_f[4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15)); mode = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (d_o[j] !== 4'b0 || f_o[j] !== 1'b0 || ov_o[j] !== 1'b0 || cnt_o[j] !== 8'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: D=%b F=%b ov=%b cnt=%0d, required 0000/0/0/0", j, d_o[j], f_o[j], ov_o[j], cnt_o[j]);
      end
    end
    rst_n = 1'b1;
    a = 4'b0001; b = 4'b0000; c = 4'b0000; mode = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ov_o[1] !== 1'b1 || d_o[1] !== 4'b0001 || cnt_o[1] !== 8'd3) begin
      failures++;
      $display("FAIL pre_async_reset: ov=%b D=%b cnt=%0d, required 1/0001/3", ov_o[1], d_o[1], cnt_o[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (d_o[j] !== 4'b0 || f_o[j] !== 1'b0 || ov_o[j] !== 1'b0 || cnt_o[j] !== 8'd0) begin
        failures++;
        $display("FAIL async_reset[%0d]: D=%b F=%b ov=%b cnt=%0d, required 0000/0/0/0", j, d_o[j], f_o[j], ov_o[j], cnt_o[j]);
      end
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_mode_sweep();
    int         idx;
    logic [3:0] ed;
    logic       ef, ev;
    logic [7:0] ec;
    for (int e = 1; e <= 7; e++) begin
      if (e <= 4) begin
        a = 4'b0101; b = 4'b0011; c = 4'b1000; mode = 2'(e - 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      for (int j = 0; j < 3; j++) begin
        idx = e - lat[j];
        if (idx >= 0 && idx <= 3) begin
          ev = 1'b1; ed = sweep_d[idx]; ef = sweep_f[idx];
        end else if (idx > 3) begin
          ev = 1'b0; ed = sweep_d[3]; ef = sweep_f[3];
        end else begin
          ev = 1'b0; ed = 4'b0; ef = 1'b0;
        end
        ec = 8'd0;
        for (int k = 0; k <= 3; k++) if (k <= idx && sweep_f[k]) ec++;
        checks++;
        if (ov_o[j] !== ev || d_o[j] !== ed || f_o[j] !== ef || cnt_o[j] !== ec) begin
          failures++;
          $display("FAIL mode_sweep[stages=%0d edge=%0d]: ov=%b D=%b F=%b cnt=%0d, required %b/%b/%b/%0d",
                   lat[j], e, ov_o[j], d_o[j], f_o[j], cnt_o[j], ev, ed, ef, ec);
        end
      end
    end
  endtask

  // STAGES=2 instance; counter enters at 3 from the sweep
  task automatic test_bubble_hold();
    a = 4'b0101; b = 4'b0011; c = 4'b1000; mode = 2'b10; in_valid = 1'b1; hold = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (ov_o[1] !== 1'b1 || d_o[1] !== 4'b0001 || f_o[1] !== 1'b1 || cnt_o[1] !== 8'd4) begin
      failures++;
      $display("FAIL bubble_deliver: ov=%b D=%b F=%b cnt=%0d, required 1/0001/1/4", ov_o[1], d_o[1], f_o[1], cnt_o[1]);
    end
    tick();
    checks++;
    if (ov_o[1] !== 1'b0 || d_o[1] !== 4'b0001 || f_o[1] !== 1'b1 || cnt_o[1] !== 8'd4) begin
      failures++;
      $display("FAIL bubble_keep: ov=%b D=%b F=%b cnt=%0d, required 0/0001/1/4", ov_o[1], d_o[1], f_o[1], cnt_o[1]);
    end
    mode = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (ov_o[1] !== 1'b1 || d_o[1] !== 4'b1110 || cnt_o[1] !== 8'd5) begin
      failures++;
      $display("FAIL pre_hold: ov=%b D=%b cnt=%0d, required 1/1110/5", ov_o[1], d_o[1], cnt_o[1]);
    end
    hold = 1'b1; in_valid = 1'b1; mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ov_o[1] !== 1'b1 || d_o[1] !== 4'b1110 || f_o[1] !== 1'b1 || cnt_o[1] !== 8'd5) begin
        failures++;
        $display("FAIL hold_frozen[%0d]: ov=%b D=%b F=%b cnt=%0d, required 1/1110/1/5", i, ov_o[1], d_o[1], f_o[1], cnt_o[1]);
      end
    end
    hold = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ov_o[1] !== 1'b0 || d_o[1] !== 4'b1110 || cnt_o[1] !== 8'd5) begin
        failures++;
        $display("FAIL hold_dropped[%0d]: ov=%b D=%b cnt=%0d, required 0/1110/5", i, ov_o[1], d_o[1], cnt_o[1]);
      end
    end
  endtask

  task automatic test_saturation_clr();
    clr = 1'b1; in_valid = 1'b0; hold = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (cnt_o[j] !== 8'd0) begin
        failures++;
        $display("FAIL clr_idle[%0d]: cnt=%0d, required 0", j, cnt_o[j]);
      end
    end
    clr = 1'b0;
    a = 4'b0001; b = 4'b0000; c = 4'b0000; mode = 2'b01; in_valid = 1'b1;
    for (int e = 1; e <= 260; e++) begin
      tick();
      if (e == 255) begin
        checks++;
        if (cnt_o[1] !== 8'd254) begin
          failures++;
          $display("FAIL sat_approach: cnt=%0d, required 254", cnt_o[1]);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (cnt_o[j] !== 8'd255) begin
        failures++;
        $display("FAIL saturate[%0d]: cnt=%0d, required 255", j, cnt_o[j]);
      end
    end
    clr = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (cnt_o[j] !== 8'd0 || ov_o[j] !== 1'b1) begin
        failures++;
        $display("FAIL clr_priority[%0d]: cnt=%0d ov=%b, required 0/1", j, cnt_o[j], ov_o[j]);
      end
    end
    clr = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (cnt_o[j] !== 8'd1) begin
        failures++;
        $display("FAIL after_clr[%0d]: cnt=%0d, required 1", j, cnt_o[j]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    a = 4'b0001; b = 4'b0000; c = 4'b0000; mode = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #2 in_valid = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (ov_o[j] !== 1'b0 || cnt_o[j] !== 8'd0 || d_o[j] !== 4'b0) begin
          failures++;
          $display("FAIL midflight[%0d,%0d]: ov=%b cnt=%0d D=%b, required 0/0/0000", i, j, ov_o[j], cnt_o[j], d_o[j]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; c = '0; mode = '0; in_valid = 1'b0; hold = 1'b0; clr = 1'b0;
    test_reset();
    test_mode_sweep();
    test_bubble_hold();
    test_saturation_clr();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/com_seq_pipe.md
# com_seq_pipe

- Parametrised successor to the single-bit combinational/sequential cell. Combines three WIDTH-bit operands through a mode-selected bitwise function and computes an odd-parity flag.
- Carries both through a STAGES-deep valid-tagged pipeline with a global hold.
- Counts delivered results whose parity flag is set.
- Sits between operand sources and any consumer needing registered, qualified logic results.

## Interface
- WIDTH, default 4: operand and result width, ≥1.
- STAGES, default 2: pipeline depth in registers, ≥1.
- CNT_W, default 8: width of the saturating match counter, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- A, B, C  in  WIDTH each  operands.
- mode  in  2  function select.
- in_valid  in  1  operands valid this cycle.
- hold  in  1  freeze the whole pipeline.
- clr  in  1  synchronous clear of match_cnt.
- D  out  WIDTH  registered result from the last stage.
- F  out  1  registered odd parity of D.
- out_valid  out  1  D/F carry a delivered item.
- match_cnt  out  CNT_W  number of delivered items with F=1, saturating.

## Operation
- Function R, combinational from the current inputs:
  - mode 00: (A&B)|C.
  - mode 01: A^B^C.
  - mode 10: majority, (A&B)|(B&C)|(A&C).
  - mode 11: ~(A|B)&C.
- Flag f = ^R, the XOR-reduce of all WIDTH bits.
- Pipeline: stages 1..STAGES, each holding {v, data[WIDTH-1:0], flag}. Stage STAGES drives out_valid/D/F.
- Edge with hold=0:
  - Stage 1 v loads in_valid.
  - Stage k>1 v loads v of stage k-1.
  - Each stage's data/flag load from the previous stage (or from R/f for stage 1) only when the incoming v=1. On a bubble, data/flag keep their old value, so D/F hold the last delivered item while out_valid=0.
- Edge with hold=1:
  - Every v, data and flag keeps its value, including out_valid.
  - Inputs are ignored, and in_valid items presented are dropped.
- match_cnt:
  - At an edge with hold=0 where the item entering stage STAGES has v=1 and flag=1, increment by 1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr=1 sets it to 0 at the next edge. clr takes priority over a simultaneous increment and works regardless of hold.
- No mode latching: mode is sampled together with the operands at stage-1 load.

## Timing
- Reset (rst_n low, asynchronous, immediate): all v=0, data=0, flag=0, so D=0, F=0, out_valid=0, match_cnt=0.
- Release is synchronous to the next rising edge. Reset asserted mid-operation flushes all in-flight items and drops them without counting.
- Latency: an item sampled at edge n with hold=0 throughout appears on D/F with out_valid=1 right after edge n+STAGES-1. With STAGES=1, outputs update right after the sampling edge.
- Each cycle with hold=1 adds one cycle of latency to every in-flight item.
- Throughput: one item per clock while hold=0.
- match_cnt updates on the same edge at which the counted item raises out_valid.
- out_valid stays high for exactly one cycle per item unless hold is high. During hold it stays high, and the item is counted only once.

## Test plan
Parameters for all scenarios: WIDTH=4, STAGES=2, CNT_W=8.

1. Reset check: hold rst_n=0 for 2 cycles with random inputs → D=0000, F=0, out_valid=0, match_cnt=0. Assert rst_n low asynchronously between edges → outputs clear immediately.
2. Mode sweep: apply A=0101, B=0011, C=1000 with in_valid=1 and mode 00,01,10,11 on 4 consecutive edges. Starting 1 cycle after the first edge, expect D/F = 1001/0, 1110/1, 0001/1, 1000/1, each with out_valid=1. match_cnt ends at 3.
3. Bubble and hold: send item mode 10 (D=0001, F=1), then in_valid=0, then hold=1 for 3 cycles → out_valid toggles 1→0, D stays 0001 during the bubble, the pipeline is frozen during hold, and match_cnt increments exactly once.
4. Saturation and clr: drive 260 consecutive F=1 items (mode 01, A=0001, B=0, C=0) → match_cnt stops at 255. Assert clr on a cycle where a counted item arrives → match_cnt=0, not 1.
5. Reset mid-flight: launch 2 items, then pulse rst_n low before either reaches stage 2 → out_valid never rises and match_cnt=0.
6. STAGES=1 and STAGES=4 re-runs of scenario 2 → latency exactly 1 and 4 edges respectively, with identical D/F sequences.
